// File: rtl/filter_ctrl_pkg.sv
// rtl/filter_ctrl_pkg.sv - shared states and control-bus constants for the filter engine sequencer
package filter_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ROWS,
        ST_WR_COLS,
        ST_WR_START,
        ST_GAP,
        ST_RD_CTRL,
        ST_DONE,
        ST_ERR
    } seq_state_t;

    localparam logic [4:0]  AP_CTRL_ADDR = 5'h00;
    localparam int          AP_START     = 0;
    localparam int          AP_DONE      = 1;
    localparam int          AP_IDLE      = 2;
    localparam int          AP_READY     = 3;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [31:0] AP_START_WORD = 32'h1 << AP_START;

endpackage

// File: rtl/axil_single_master.sv
// rtl/axil_single_master.sv - one-shot AXI4-Lite read/write engine, one transaction at a time
module axil_single_master
    import filter_ctrl_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    logic wr_act;
    logic bready_set;
    logic b_fire;
    logic r_fire;

    // Address and data phases may finish in any order; bready waits for whichever is last.
    assign bready_set = wr_act && !m_axi_bready
                        && (!m_axi_awvalid || m_axi_awready)
                        && (!m_axi_wvalid  || m_axi_wready);
    assign b_fire   = m_axi_bvalid && m_axi_bready;
    assign r_fire   = m_axi_rvalid && m_axi_rready;
    assign ack      = b_fire || r_fire;
    assign resp_err = (b_fire && m_axi_bresp != RESP_OKAY) || (r_fire && m_axi_rresp != RESP_OKAY);
    assign rdata    = m_axi_rdata;
    assign m_axi_wstrb = 4'hF;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_act        <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
            if (bready_set)                     m_axi_bready  <= 1'b1;
            if (b_fire) begin
                m_axi_bready <= 1'b0;
                wr_act       <= 1'b0;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_arvalid <= 1'b0;
                m_axi_rready  <= 1'b1;
            end
            if (r_fire) m_axi_rready <= 1'b0;
            // A new request may arrive in the same cycle the previous one acks.
            if (req) begin
                if (we) begin
                    wr_act        <= 1'b1;
                    m_axi_awaddr  <= addr;
                    m_axi_awvalid <= 1'b1;
                    m_axi_wdata   <= wdata;
                    m_axi_wvalid  <= 1'b1;
                end else begin
                    m_axi_araddr  <= addr;
                    m_axi_arvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/filter_engine_sequencer.sv
// rtl/filter_engine_sequencer.sv - configures and sequences image_filter_top frames over AXI4-Lite
module filter_engine_sequencer
    import filter_ctrl_pkg::*;
#(
    parameter int              ADDR_W    = 5,
    parameter int              DIM_W     = 12,
    parameter logic [ADDR_W-1:0] ROWS_ADDR = ADDR_W'('h14),
    parameter logic [ADDR_W-1:0] COLS_ADDR = ADDR_W'('h1C),
    parameter int              POLL_GAP  = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              continuous,
    input  logic              stop,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic [DIM_W-1:0]  cfg_cols,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              err,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int GAP_W = $clog2(POLL_GAP + 1);

    seq_state_t        state, next_state;
    logic [GAP_W-1:0]  gap_cnt;
    logic              stop_pend;
    logic              cont_q;
    logic [DIM_W-1:0]  cols_q;

    logic              req, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              ack, resp_err;
    logic [31:0]       rdata;
    logic              start_ok;

    assign busy       = (state != ST_IDLE) && (state != ST_ERR);
    assign frame_done = (state == ST_DONE);
    assign start_ok   = start && (state == ST_IDLE || state == ST_ERR);

    always_comb begin
        next_state = state;
        req        = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        case (state)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    next_state = ST_WR_ROWS;
                    req        = 1'b1;
                    req_we     = 1'b1;
                    req_addr   = ROWS_ADDR;
                    req_wdata  = {{(32-DIM_W){1'b0}}, cfg_rows};
                end
            end
            ST_WR_ROWS: begin
                if (ack) begin
                    if (resp_err) begin
                        next_state = ST_ERR;
                    end else begin
                        next_state = ST_WR_COLS;
                        req        = 1'b1;
                        req_we     = 1'b1;
                        req_addr   = COLS_ADDR;
                        req_wdata  = {{(32-DIM_W){1'b0}}, cols_q};
                    end
                end
            end
            ST_WR_COLS: begin
                if (ack) begin
                    if (resp_err) begin
                        next_state = ST_ERR;
                    end else begin
                        next_state = ST_WR_START;
                        req        = 1'b1;
                        req_we     = 1'b1;
                        req_addr   = ADDR_W'(AP_CTRL_ADDR);
                        req_wdata  = AP_START_WORD;
                    end
                end
            end
            ST_WR_START: begin
                if (ack) next_state = resp_err ? ST_ERR : ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    next_state = ST_RD_CTRL;
                    req        = 1'b1;
                    req_addr   = ADDR_W'(AP_CTRL_ADDR);
                end
            end
            ST_RD_CTRL: begin
                if (ack) begin
                    if (resp_err)           next_state = ST_ERR;
                    else if (rdata[AP_DONE]) next_state = ST_DONE;
                    else                    next_state = ST_GAP;
                end
            end
            ST_DONE: begin
                if (cont_q && !stop_pend) begin
                    next_state = ST_WR_ROWS;
                    req        = 1'b1;
                    req_we     = 1'b1;
                    req_addr   = ROWS_ADDR;
                    req_wdata  = {{(32-DIM_W){1'b0}}, cfg_rows};
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            gap_cnt     <= '0;
            stop_pend   <= 1'b0;
            cont_q      <= 1'b0;
            cols_q      <= '0;
            frame_count <= '0;
            err         <= 1'b0;
        end else begin
            state <= next_state;
            if (start_ok) begin
                cont_q      <= continuous;
                frame_count <= '0;
                err         <= 1'b0;
                stop_pend   <= stop;
            end else if (busy && stop) begin
                stop_pend <= 1'b1;
            end
            if (next_state == ST_IDLE && state != ST_IDLE) stop_pend <= 1'b0;
            if (state == ST_DONE) frame_count <= frame_count + 16'd1;
            if (next_state == ST_ERR && state != ST_ERR) err <= 1'b1;
            // Columns are captured alongside rows so both belong to the same frame.
            if (next_state == ST_WR_ROWS && state != ST_WR_ROWS) cols_q <= cfg_cols;
            if (next_state == ST_GAP && state != ST_GAP) gap_cnt <= GAP_W'(POLL_GAP - 1);
            else if (state == ST_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
    end

    axil_single_master #(.ADDR_W(ADDR_W)) u_master (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .req           (req),
        .we            (req_we),
        .addr          (req_addr),
        .wdata         (req_wdata),
        .ack           (ack),
        .rdata         (rdata),
        .resp_err      (resp_err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

endmodule

// File: tb/tb_filter_engine_sequencer.sv
// tb/tb_filter_engine_sequencer.sv - self-checking bench with a reactive AXI-Lite slave and frame model
module tb_filter_engine_sequencer;

    logic        aclk;
    logic        aresetn;
    logic        start, continuous, stop;
    logic [11:0] cfg_rows, cfg_cols;
    logic        busy, frame_done, err;
    logic [15:0] frame_count;
    logic [4:0]  m_axi_awaddr, m_axi_araddr;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic        m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    filter_engine_sequencer dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .continuous(continuous), .stop(stop),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count), .err(err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;

    // Slave behaviour knobs and transaction log.
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, done_poll = 1;
    logic        err_en = 1'b0;
    logic [4:0]  err_addr = 5'h1C;
    logic [4:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [4:0]  ra_q[$];
    int          fd_count = 0, cyc = 0, fd_cyc = 0, done_r_cyc = 0;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0, poll_idx = 0;
    logic        got_aw = 1'b0, got_w = 1'b0, pending_r = 1'b0;
    logic [4:0]  last_aw = '0;

    always @(negedge aclk) begin
        cyc++;
        if (!aresetn) begin
            m_axi_awready = 1'($urandom);
            m_axi_wready  = 1'($urandom);
            m_axi_bvalid  = 1'($urandom);
            m_axi_bresp   = 2'($urandom);
            m_axi_arready = 1'($urandom);
            m_axi_rvalid  = 1'($urandom);
            m_axi_rresp   = 2'($urandom);
            m_axi_rdata   = $urandom;
            aw_wait = 0; w_wait = 0; ar_wait = 0;
            got_aw = 1'b0; got_w = 1'b0; pending_r = 1'b0;
        end else begin
            if (frame_done) begin
                fd_count++;
                fd_cyc = cyc;
            end
            m_axi_awready = 1'b0;
            if (m_axi_awvalid) begin
                if (aw_wait >= aw_delay) begin
                    m_axi_awready = 1'b1;
                    aw_wait = 0;
                    wa_q.push_back(m_axi_awaddr);
                    last_aw = m_axi_awaddr;
                    got_aw = 1'b1;
                    if (m_axi_awaddr == 5'h00) poll_idx = 0;
                end else aw_wait++;
            end
            m_axi_wready = 1'b0;
            if (m_axi_wvalid) begin
                if (w_wait >= w_delay) begin
                    m_axi_wready = 1'b1;
                    w_wait = 0;
                    wd_q.push_back(m_axi_wdata);
                    got_w = 1'b1;
                end else w_wait++;
            end
            if (m_axi_bvalid) m_axi_bvalid = 1'b0;
            else if (got_aw && got_w && m_axi_bready) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (err_en && last_aw == err_addr) ? 2'b10 : 2'b00;
                got_aw = 1'b0;
                got_w  = 1'b0;
            end
            m_axi_arready = 1'b0;
            if (m_axi_arvalid) begin
                if (ar_wait >= ar_delay) begin
                    m_axi_arready = 1'b1;
                    ar_wait = 0;
                    ra_q.push_back(m_axi_araddr);
                    pending_r = 1'b1;
                end else ar_wait++;
            end
            if (m_axi_rvalid) m_axi_rvalid = 1'b0;
            else if (pending_r && m_axi_rready) begin
                pending_r = 1'b0;
                poll_idx++;
                m_axi_rresp  = 2'b00;
                m_axi_rdata  = $urandom & ~32'h2;
                if (poll_idx >= done_poll) begin
                    m_axi_rdata[1] = 1'b1;
                    done_r_cyc = cyc;
                end
                m_axi_rvalid = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
        fd_count = 0;
    endtask

    task automatic start_run(input logic cont, input string tag);
        @(negedge aclk);
        start = 1'b1;
        continuous = cont;
        @(negedge aclk);
        start = 1'b0;
        check({tag, "_start_latency_awvalid"}, 32'(m_axi_awvalid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    // Reference: each frame is ROWS, COLS, AP_START writes, then `polls` AP_CTRL reads.
    task automatic verify_frames(input string tag, input int frames, input logic [11:0] rows,
                                 input logic [11:0] cols, input int polls);
        logic [4:0]  ea[$];
        logic [31:0] ed[$];
        for (int f = 0; f < frames; f++) begin
            ea.push_back(5'h14); ed.push_back(32'(rows));
            ea.push_back(5'h1C); ed.push_back(32'(cols));
            ea.push_back(5'h00); ed.push_back(32'h1);
        end
        check({tag, "_write_addr_count"}, 32'(wa_q.size()), 32'(ea.size()));
        check({tag, "_write_data_count"}, 32'(wd_q.size()), 32'(ed.size()));
        for (int i = 0; i < ea.size() && i < wa_q.size() && i < wd_q.size(); i++) begin
            check($sformatf("%s_waddr%0d", tag, i), 32'(wa_q[i]), 32'(ea[i]));
            check($sformatf("%s_wdata%0d", tag, i), wd_q[i], ed[i]);
        end
        check({tag, "_read_count"}, 32'(ra_q.size()), 32'(frames * polls));
        for (int i = 0; i < ra_q.size(); i++) check($sformatf("%s_raddr%0d", tag, i), 32'(ra_q[i]), 32'h0);
        check({tag, "_frame_done_pulses"}, 32'(fd_count), 32'(frames));
        check({tag, "_frame_count"}, 32'(frame_count), 32'(frames));
    endtask

    initial begin
        logic [11:0] r, c;
        int n;
        aresetn = 1'b0; start = 1'b0; continuous = 1'b0; stop = 1'b0;
        cfg_rows = '0; cfg_cols = '0;

        // 1: reset with random slave inputs
        repeat (5) @(negedge aclk);
        #1;
        check("rst_awvalid", 32'(m_axi_awvalid), 0);
        check("rst_wvalid", 32'(m_axi_wvalid), 0);
        check("rst_bready", 32'(m_axi_bready), 0);
        check("rst_arvalid", 32'(m_axi_arvalid), 0);
        check("rst_rready", 32'(m_axi_rready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        check("rst_awaddr", 32'(m_axi_awaddr), 0);
        check("rst_araddr", 32'(m_axi_araddr), 0);
        check("rst_wdata", m_axi_wdata, 0);
        check("rst_wstrb", 32'(m_axi_wstrb), 32'hF);
        @(posedge aclk); #2 aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_awvalid", 32'(m_axi_awvalid), 0);

        // 2: single shot, done on third poll
        clear_logs();
        cfg_rows = 12'd480; cfg_cols = 12'd640; done_poll = 3;
        start_run(1'b0, "single");
        wait_idle("single");
        verify_frames("single", 1, 12'd480, 12'd640, 3);
        check("single_done_latency", 32'(fd_cyc - done_r_cyc), 32'd1);
        check("single_err", 32'(err), 0);

        // 3: handshake skew both ways, random sizes
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            aw_delay = (k == 0) ? 0 : 3;
            w_delay  = (k == 0) ? 3 : 0;
            done_poll = 1;
            r = 12'($urandom_range(1, 4095)); c = 12'($urandom_range(1, 4095));
            cfg_rows = r; cfg_cols = c;
            start_run(1'b0, $sformatf("skew%0d", k));
            wait_idle($sformatf("skew%0d", k));
            verify_frames($sformatf("skew%0d", k), 1, r, c, 1);
        end
        aw_delay = 0; w_delay = 0;

        // 4: continuous, stop during the second frame's poll gap
        clear_logs();
        done_poll = $urandom_range(1, 3);
        r = 12'($urandom_range(1, 4095)); c = 12'($urandom_range(1, 4095));
        cfg_rows = r; cfg_cols = c;
        start_run(1'b1, "cont");
        n = 0;
        while (wa_q.size() < 6 && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        check("cont_second_frame_timeout", 32'(wa_q.size() >= 6), 32'd1);
        repeat (8) @(negedge aclk);
        stop = 1'b1;
        @(negedge aclk);
        stop = 1'b0;
        check("cont_busy_after_stop", 32'(busy), 1);
        wait_idle("cont");
        verify_frames("cont", 2, r, c, done_poll);
        continuous = 1'b0;

        // 5: bus error on the COLS write
        clear_logs();
        err_en = 1'b1; err_addr = 5'h1C; done_poll = 1;
        cfg_rows = 12'd100; cfg_cols = 12'd200;
        start_run(1'b0, "err");
        wait_idle("err");
        check("err_flag", 32'(err), 1);
        check("err_busy", 32'(busy), 0);
        check("err_write_count", 32'(wa_q.size()), 2);
        check("err_last_waddr", 32'(wa_q[wa_q.size()-1]), 32'h1C);
        check("err_reads", 32'(ra_q.size()), 0);
        check("err_frame_count", 32'(frame_count), 0);
        err_en = 1'b0;
        clear_logs();
        start_run(1'b0, "err_restart");
        check("err_cleared_by_start", 32'(err), 0);
        wait_idle("err_restart");
        verify_frames("err_restart", 1, 12'd100, 12'd200, 1);

        // 6: asynchronous reset while a read address is pending
        clear_logs();
        ar_delay = 40;
        start_run(1'b0, "midrd");
        n = 0;
        while (!m_axi_arvalid && n < 500) begin
            @(negedge aclk);
            n++;
        end
        check("midrd_arvalid_seen", 32'(m_axi_arvalid), 1);
        #2 aresetn = 1'b0;
        #1;
        check("midrd_arvalid_async", 32'(m_axi_arvalid), 0);
        check("midrd_busy_async", 32'(busy), 0);
        @(posedge aclk); #2 aresetn = 1'b1;
        ar_delay = 0;
        clear_logs();
        r = 12'($urandom_range(1, 4095)); c = 12'($urandom_range(1, 4095));
        cfg_rows = r; cfg_cols = c; done_poll = 2;
        start_run(1'b0, "fresh");
        wait_idle("fresh");
        verify_frames("fresh", 1, r, c, 2);
        check("fresh_err", 32'(err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
